// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched by index
// from an external key-schedule store, start/ready/done request handshake.
module inv_cipher #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] in,
  output logic         ready,
  output logic [3:0]   keyIdx,
  input  logic [127:0] roundKey,
  output logic [127:0] out,
  output logic         done
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
    $error("inv_cipher: NR must be 10, 12 or 14");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE} state_t;

  localparam logic [3:0] NR_IDX = 4'(NR);

  // Entry b of the FIPS-197 inverse S-box sits at bits [2047-8*b -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte s[r,c] lives at data[127-8*(r+4c) -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = s[127 - 8*(r + 4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Coefficients 0e/0b/0d/09 assembled from the x2, x4, x8 multiples of each byte.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4], mb [4], md [4], me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8*(r + 4*c) -: 8];
        x2    = xtime(a[r]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127 - 8*(0 + 4*c) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[127 - 8*(1 + 4*c) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[127 - 8*(2 + 4*c) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[127 - 8*(3 + 4*c) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] stm_q, stm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] out_q, out_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic [3:0]   key_idx_q, key_idx_d;
  logic [127:0] add_key;

  // Shared by ROUND (feeds InvMixColumns) and FINAL (is the plaintext).
  assign add_key = inv_sub_bytes(inv_shift_rows(stm_q)) ^ roundKey;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    stm_d     = stm_q;
    rnd_d     = rnd_q;
    out_d     = out_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    key_idx_d = key_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stm_d     = in;
          ready_d   = 1'b0;
          key_idx_d = NR_IDX;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        stm_d     = stm_q ^ roundKey;
        rnd_d     = NR_IDX - 4'd1;
        key_idx_d = NR_IDX - 4'd1;
        state_d   = S_ROUND;
      end
      S_ROUND: begin
        stm_d     = inv_mix_columns(add_key);
        rnd_d     = rnd_q - 4'd1;
        key_idx_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        out_d     = add_key;
        done_d    = 1'b1;
        key_idx_d = NR_IDX;
        state_d   = S_DONE;
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d   = 1'b1;
        key_idx_d = NR_IDX;
        state_d   = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      stm_q     <= '0;
      rnd_q     <= '0;
      out_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      key_idx_q <= NR_IDX;
    end else begin
      state_q   <= state_d;
      stm_q     <= stm_d;
      rnd_q     <= rnd_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      key_idx_q <= key_idx_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign keyIdx = key_idx_q;
  assign out    = out_q;

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher: NR=10/12/14 instances fed from a bench-side AES key-expansion
// model, FIPS-197 vectors, latency, handshake, reset-abort and output-hold checks.
module tb_inv_cipher;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] KB  = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] K2  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] LK1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] LKB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         reset;
  logic         start_v [0:2];
  logic [127:0] in_v    [0:2];
  wire          ready_v [0:2];
  wire          done_v  [0:2];
  wire  [3:0]   kidx_v  [0:2];
  wire  [127:0] out_v   [0:2];
  wire  [127:0] rk_v    [0:2];
  logic [127:0] ks      [0:2][0:15];
  logic [31:0]  w       [0:63];
  logic         rk_rand_en;
  logic [127:0] rk_rand;
  int           n_tests;
  int           n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rk_v[g] = rk_rand_en ? rk_rand : ks[g][kidx_v[g]];
    inv_cipher #(.NR(10 + 2*g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[g]),
      .in       (in_v[g]),
      .ready    (ready_v[g]),
      .keyIdx   (kidx_v[g]),
      .roundKey (rk_v[g]),
      .out      (out_v[g]),
      .done     (done_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Standard FIPS-197 key expansion into the key table of instance s.
  task automatic load_keys(input int s, input logic [255:0] key, input int nk);
    int         nr;
    logic [31:0] t;
    logic [7:0]  rcon;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k < 16; k++)
      ks[s][k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_kidx(input int n, input int nr);
    if (n == 0) return nr;
    if (n < nr) return nr - n;
    if (n == nr) return 0;
    return nr;
  endfunction

  // One full decryption on instance s with per-cycle keyIdx and latency checks.
  task automatic run(input int s, input logic [127:0] ct, input logic [127:0] pt,
                     input logic [127:0] load_key, input bit chk_load, input string tag);
    int nr;
    int n;
    nr = 10 + 2*s;
    check({tag, "_ready_before"}, 128'(ready_v[s]), 128'd1);
    in_v[s]    = ct;
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    in_v[s]    = '0;
    if (chk_load) check({tag, "_load_key"}, rk_v[s], load_key);
    n = 0;
    while (!done_v[s] && n < 40) begin
      check($sformatf("%s_kidx_%0d", tag, n), 128'(kidx_v[s]), 128'(exp_kidx(n, nr)));
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(nr + 1));
    check({tag, "_out"}, out_v[s], pt);
    check({tag, "_ready_in_done"}, 128'(ready_v[s]), 128'd0);
    check({tag, "_kidx_done"}, 128'(kidx_v[s]), 128'(nr));
    tick();
    check({tag, "_done_width"}, 128'(done_v[s]), 128'd0);
    check({tag, "_ready_after"}, 128'(ready_v[s]), 128'd1);
    check({tag, "_out_held"}, out_v[s], pt);
  endtask

  initial begin
    int n;
    bit saw;
    n_tests    = 0;
    n_fail     = 0;
    rk_rand_en = 1'b0;
    rk_rand    = '0;
    for (int s = 0; s < 3; s++) begin
      start_v[s] = 1'b0;
      in_v[s]    = '0;
      for (int k = 0; k < 16; k++) ks[s][k] = '0;
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_ready_%0d", s), 128'(ready_v[s]), 128'd1);
      check($sformatf("rst_done_%0d", s), 128'(done_v[s]), 128'd0);
      check($sformatf("rst_out_%0d", s), out_v[s], 128'd0);
      check($sformatf("rst_kidx_%0d", s), 128'(kidx_v[s]), 128'(10 + 2*s));
    end

    load_keys(0, K1, 4);
    run(0, CT1, PT1, LK1, 1'b1, "c1");
    load_keys(0, KB, 4);
    run(0, CTB, PTB, LKB, 1'b1, "appb");
    load_keys(1, K2, 6);
    run(1, CT2, PT1, '0, 1'b0, "c2");
    load_keys(2, K3, 8);
    run(2, CT3, PT1, '0, 1'b0, "c3");

    // start held high; in changes mid-block; key table swapped while in DONE
    load_keys(0, K1, 4);
    in_v[0]    = CT1;
    start_v[0] = 1'b1;
    tick();
    n = 0;
    while (!done_v[0] && n < 40) begin
      tick();
      n++;
      if (n == 4) in_v[0] = CTB;
    end
    check("b2b_lat1", 128'(n), 128'd11);
    check("b2b_out1", out_v[0], PT1);
    load_keys(0, KB, 4);
    tick();
    check("b2b_done_width1", 128'(done_v[0]), 128'd0);
    n = 1;
    while (!done_v[0] && n < 40) begin
      tick();
      n++;
    end
    start_v[0] = 1'b0;
    check("b2b_period", 128'(n), 128'd13);
    check("b2b_out2", out_v[0], PTB);
    tick();
    check("b2b_done_width2", 128'(done_v[0]), 128'd0);
    check("b2b_ready_after", 128'(ready_v[0]), 128'd1);

    // reset and start on the same edge: reset wins
    load_keys(0, K1, 4);
    reset      = 1'b1;
    start_v[0] = 1'b1;
    in_v[0]    = CT1;
    tick();
    reset      = 1'b0;
    start_v[0] = 1'b0;
    check("rst_start_ready", 128'(ready_v[0]), 128'd1);
    check("rst_start_kidx", 128'(kidx_v[0]), 128'd10);
    tick();
    check("rst_start_ready2", 128'(ready_v[0]), 128'd1);

    // complete a block so out is nonzero, then abort the next one in its cycle 5
    run(0, CT1, PT1, LK1, 1'b1, "c1_pre_abort");
    in_v[0]    = CT1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 128'(ready_v[0]), 128'd1);
    check("abort_out", out_v[0], 128'd0);
    check("abort_done", 128'(done_v[0]), 128'd0);
    check("abort_kidx", 128'(kidx_v[0]), 128'd10);
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (done_v[0]) saw = 1'b1;
    end
    check("abort_no_done", 128'(saw), 128'd0);
    run(0, CT1, PT1, LK1, 1'b1, "c1_after_abort");

    // out must hold while in and roundKey wander with start low
    rk_rand_en = 1'b1;
    repeat (50) begin
      in_v[0] = {$urandom, $urandom, $urandom, $urandom};
      rk_rand = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("hold_out", out_v[0], PT1);
      check("hold_done", 128'(done_v[0]), 128'd0);
    end
    rk_rand_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_cipher.md
# inv_cipher

Iterative AES inverse cipher (decryption) core and the receive-side counterpart of the encryption datapath. It takes a 128-bit ciphertext block and produces the plaintext, running one inverse round per clock. Round keys come from the key-schedule store through an indexed lookup, and requests arrive through a start/ready/done handshake. The block sits between the key-expansion storage and the message-buffer logic.

## Interface

Parameters:
- NR, default 10: number of AES rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Any other value is illegal and is rejected by an elaboration-time assertion.

Ports (reset is synchronous, active-high; clock is clk):
- clk, input, 1: system clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a decryption. Sampled only when ready=1.
- in, input, 128: ciphertext block. Sampled on the same edge as an accepted start.
- ready, output, 1: core is idle and will accept start.
- keyIdx, output, 4: index (0..NR) of the round key needed this cycle.
- roundKey, input, 128: round key w[4*keyIdx .. 4*keyIdx+3]. Must be valid combinationally in the same cycle as keyIdx.
- out, output, 128: plaintext. Registered, and held stable between completions.
- done, output, 1: one-cycle pulse marking that out holds a new plaintext.

## Operation

- Byte map follows FIPS-197 column-major order: s[r,c] = data[127-8*(r+4c) -: 8].
- Internal registers:
  - stm[127:0]: working state.
  - rnd[3:0]: round counter.
  - out[127:0]: output register.
  - FSM state.
- FSM states and transitions:
  - IDLE: ready=1, keyIdx=NR. When start=1, load stm<=in and go to LOAD. When start=0, stay in IDLE.
  - LOAD: keyIdx=NR. Update stm <= stm ^ roundKey and rnd <= NR-1, then go to ROUND.
  - ROUND: keyIdx=rnd. Update stm <= InvMixColumns(InvSubBytes(InvShiftRows(stm)) ^ roundKey) and rnd <= rnd-1. When rnd==1, go to FINAL; otherwise stay in ROUND.
  - FINAL: keyIdx=0. Update out <= InvSubBytes(InvShiftRows(stm)) ^ roundKey, then go to DONE.
  - DONE: done=1, ready=0, keyIdx=NR. Next state is IDLE.
- Transform definitions:
  - InvShiftRows: row r is rotated right by r bytes, i.e. s'[r,(c+r) mod 4] = s[r,c].
  - InvSubBytes: FIPS-197 inverse S-box, implemented as a 256-entry constant table inside the block.
  - InvMixColumns: per column, multiply by the matrix {0e,0b,0d,09}, rotated per row, in GF(2^8) with reduction polynomial 0x11b. Build it from a chained xtime.
- Widths: no arithmetic other than the 4-bit rnd decrement. rnd never underflows, because it stops at 1.
- start is ignored in LOAD, ROUND, FINAL and DONE; no queuing. in is not sampled outside an accepted start.
- roundKey is only consumed in LOAD, ROUND and FINAL. Its value in other states is don't-care.
- out changes only in FINAL, or on reset. It holds the last plaintext indefinitely.

## Timing

- Reset values:
  - FSM state = IDLE.
  - stm = 0, rnd = 0, out = 0.
  - done = 0, ready = 1, keyIdx = NR.
- Latency: start is accepted at edge E0. Then:
  - LOAD runs at edge E1.
  - ROUND runs at edges E2..E_NR.
  - FINAL runs at edge E_NR+1.
  - done is high for the cycle after E_NR+1.
  - For NR=10, done rises 11 cycles after the accepting edge; 13 cycles for NR=12; 15 cycles for NR=14.
- ready drops on E0 and returns after the DONE cycle. Back-to-back throughput is one block per NR+3 cycles.
- keyIdx is a registered function of state/rnd and never glitches mid-cycle. The key store has a full cycle of combinational lookup.
- Reset mid-operation: on the next edge the FSM goes to IDLE and out=0, and done is never asserted for the aborted block.
- Simultaneous reset and start: reset wins and start is dropped.
- start held high continuously: a new block is accepted on the first IDLE cycle after DONE, and in is sampled at that point.

## Test plan

- NR=10 FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench key-table model); in=69c4e0d86a7b0430d8cdb78070b4c55a; start pulse.
  - Required response: out=00112233445566778899aabbccddeeff; done exactly 11 cycles after acceptance; keyIdx steps 10,10,9..1,0.
  - Required response: in the LOAD cycle, with keyIdx=10, roundKey=13111d7fe3944a17f307a78b4d2b30c5.
- NR=10 FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c (w[40..43]=d014f9a8c9ee2589e13f0cc8b6630ca6); in=3925841d02dc09fbdc118597196a0b32.
  - Required response: out=3243f6a8885a308d313198a2e0370734.
- NR=12 and NR=14 instances:
  - Stimulus: C.2 key 000102..1617 with ct dda97ca4864cdfe06eaf70a0ec0d7191; C.3 key 000102..1e1f with ct 8ea2b7ca516745bfeafc49904b496089.
  - Required response: out=00112233445566778899aabbccddeeff for both; done at 13 and 15 cycles respectively.
- Busy-ignore / back-to-back:
  - Stimulus: start held high with in toggled mid-operation.
  - Required response: the first result is unaffected by the in change; the second block starts only after DONE; each done is exactly one cycle wide.
- Reset mid-operation:
  - Stimulus: assert reset in cycle 5 of a decryption.
  - Required response: next cycle shows ready=1, out=0, done=0; no done pulse follows; a fresh C.1 run afterwards still passes.
- Output hold:
  - Stimulus: after completion, toggle in and roundKey randomly for 50 cycles with start=0.
  - Required response: out stays constant; done stays 0.
